// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (divide datapath under `MULDIV_DIV_EN`)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Extra counter bit: the counter runs WIDTH-1..0 over the iterations and
    // wraps negative, which spends one further CALC cycle on the sign fix-up.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // product low half / dividend-quotient
    logic [WIDTH-1:0] addend_q, addend_d; // multiplicand / divisor magnitude
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       f3_q, f3_d;
    logic             sa_q, sa_d, sb_q, sb_d;
`ifdef MULDIV_DIV_EN
    logic             div0_q, div0_d;
    logic [WIDTH:0]   div_shift, div_diff;
`endif

    logic             signed_a, signed_b, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] fin_res;

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

    // Operand signedness and magnitudes at acceptance
    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a    = signed_a & op_a[WIDTH-1];
        neg_b    = signed_b & op_b[WIDTH-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
    end

    // One shift-add / restoring-divide step and the final signed result
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : {(WIDTH+1){1'b0}});
`ifdef MULDIV_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, addend_q};
`endif
        prod     = {hi_q, lo_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        fin_res  = '0;
        case (f3_q)
            3'b000:                 fin_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
            // Signed overflow needs no special path: |a|/1 negated wraps back
            // to the most-negative value and the remainder is zero.
            3'b100:  fin_res = div0_q ? '1 : ((sa_q ^ sb_q) ? -lo_q : lo_q);
            3'b101:  fin_res = div0_q ? '1 : lo_q;
            3'b110:  fin_res = sa_q ? -hi_q : hi_q;
            3'b111:  fin_res = hi_q;
`endif
            default: fin_res = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        addend_d = addend_q;
        result_d = result_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
`ifdef MULDIV_DIV_EN
        div0_d   = div0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = CW'(WIDTH - 1);
                    f3_d     = funct3;
                    sa_d     = neg_a;
                    sb_d     = neg_b;
                    hi_d     = '0;
                    lo_d     = mag_b;
                    addend_d = mag_a;
`ifdef MULDIV_DIV_EN
                    div0_d   = (op_b == '0);
                    if (funct3[2]) begin
                        lo_d     = mag_a;
                        addend_d = mag_b;
                    end
`endif
                end
            end
            S_CALC: begin
                if (cnt_q[CW-1]) begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    hi_d  = mul_sum[WIDTH:1];
                    lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
                    if (f3_q[2]) begin
                        if (!div_diff[WIDTH]) begin
                            hi_d = div_diff[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronous reset aborts any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            addend_q <= '0;
            result_q <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            addend_q <= addend_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
`ifdef MULDIV_DIV_EN
            div0_q   <= div0_d;
`endif
        end
    end

endmodule
